window_gen: RTL and testbench
=============================

Name: window_gen

Overview:
- Parametrised streaming K×K sliding-window generator for the conv engine; successor to the fixed 3×3 line buffer.
- Accepts one raster-order pixel per accepted cycle under a valid qualifier and stores KSIZE-1 previous rows in circular row memories.
- Emits a flattened KSIZE×KSIZE window with window_valid only at legal, stride-aligned output positions.
- Tracks row/column position, supports frame restart and input stalls, and flags end of frame.

Parameters:
DATA_WIDTH, 16, pixel width in bits (signed)
KSIZE, 3, kernel edge; legal 2..7
IMG_WIDTH, 8, pixels per row; must be >= KSIZE
IMG_HEIGHT, 8, rows per frame; must be >= KSIZE
STRIDE, 1, output stride in both axes; legal 1..KSIZE

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserts when 0)
sof  input  1  start of frame; qualified by din_valid, forces this pixel to be (row 0, col 0)
din_valid  input  1  din is valid this cycle; a low value stalls all state
din  input  DATA_WIDTH  signed pixel, raster order
window_flat  output  KSIZE*KSIZE*DATA_WIDTH  window; element (r,c) at bits [(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest row, c=0 is the leftmost column
window_valid  output  1  window_flat holds a legal window (one-cycle pulse per window)
out_row  output  clog2(IMG_HEIGHT)  row index of the window's bottom-right pixel
out_col  output  clog2(IMG_WIDTH)  column index of the window's bottom-right pixel
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (reset=0, asynchronous): counters go to 0. Window registers, window_flat, window_valid, out_row, out_col and frame_done go to 0. Row memory contents are don't-care.
- Accept: a pixel is accepted on a clock edge when din_valid=1. When din_valid=0, nothing changes and window_valid/frame_done drop to 0 on the next edge.
- Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the pixel being accepted.
  - col increments on each accept.
  - At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
- sof=1 with din_valid=1 treats din as (0,0); the counters become (0,1) next. A mid-frame sof abandons the current frame, and no frame_done is produced for it.
- Row memories: KSIZE-1 memories of IMG_WIDTH entries each, addressed by col.
  - On accept, memory k is read at col, and memory k+1 takes the value read from memory k.
  - Memory 0 takes din.
  - Effect: column col of rows row-1 … row-KSIZE+1 is available when din arrives.
- Window registers: KSIZE rows × KSIZE columns.
  - On accept, each row shifts left by one (c ← c+1).
  - The new rightmost column is {mem[KSIZE-2] out, …, mem[0] out, din}, top to bottom.
- Window legality, evaluated on the accepted pixel's position:
  - row >= KSIZE-1 and col >= KSIZE-1.
  - (row-(KSIZE-1)) mod STRIDE == 0 and (col-(KSIZE-1)) mod STRIDE == 0.
  - Use phase counters; no divider.
- Latency: window_valid, window_flat, out_row and out_col are registered and updated on the same edge that accepts the completing pixel, i.e. valid one cycle after that pixel is presented. window_valid is a pulse; window_flat holds its value until the next accept.
- Windows never straddle rows: column legality excludes wrap positions. Stale data from the previous frame is never emitted because legality restarts at row 0.
- frame_done is registered: it pulses 1 on the edge that accepts pixel (IMG_HEIGHT-1, IMG_WIDTH-1). It may coincide with window_valid.
- Windows per frame: ((IMG_HEIGHT-KSIZE)/STRIDE+1) × ((IMG_WIDTH-KSIZE)/STRIDE+1), integer division.
- Reset mid-frame: all outputs clear immediately; the next accepted pixel is (0,0).

Test Plan:
- KSIZE=3, W=H=4, STRIDE=1, stream pixels 1..16 back-to-back with sof on pixel 1 -> exactly 4 window_valid pulses.
  - First window after pixel 11: rows {1,2,3},{5,6,7},{9,10,11}, out_row=2, out_col=2.
  - Last window: {6,7,8},{10,11,12},{14,15,16}.
  - frame_done pulses with the last window.
- Same stream with din_valid toggled randomly (about 50% duty) -> identical window sequence and values. No window_valid or frame_done pulse occurs on any cycle following a stall.
- STRIDE=2, W=H=5, KSIZE=3, pixels 1..25 -> 4 windows at (2,2), (2,4), (4,2), (4,4). The window at (4,4) is {13,14,15},{18,19,20},{23,24,25}.
- Two frames back-to-back (pixels 1..16, then 101..116) -> frame 2 yields 4 windows with no frame-1 values in them. Its first window is {101,102,103},{105,106,107},{109,110,111}.
- sof asserted on pixel 7 of a frame, then 16 fresh pixels -> no frame_done for the aborted frame, and the new frame produces 4 correct windows.
- Assert reset low asynchronously mid-frame, between clock edges -> all outputs read 0 before the next edge. After release, the next stream is counted from (0,0).

Source files
------------

// File: rtl/window_gen.sv
// Streaming KSIZE x KSIZE sliding-window generator built on circular row memories.
// Emits stride-aligned windows in raster order; din_valid low freezes all state.
module window_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int KSIZE      = 3,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8,
   parameter int STRIDE     = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              sof,
   input  logic                              din_valid,
   input  logic [DATA_WIDTH-1:0]             din,
   output logic [KSIZE*KSIZE*DATA_WIDTH-1:0] window_flat,
   output logic                              window_valid,
   output logic [$clog2(IMG_HEIGHT)-1:0]     out_row,
   output logic [$clog2(IMG_WIDTH)-1:0]      out_col,
   output logic                              frame_done
);

   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam int NMEM  = KSIZE - 1;

   localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(KSIZE - 1);
   localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(KSIZE - 1);
   localparam logic [PH_W-1:0]  PH_LAST       = PH_W'(STRIDE - 1);

   // Position of the next expected pixel and its stride phase.
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [PH_W-1:0]  col_ph_q, col_ph_d;
   logic [PH_W-1:0]  row_ph_q, row_ph_d;

   logic [COL_W-1:0] cur_col;
   logic [ROW_W-1:0] cur_row;
   logic [PH_W-1:0]  cur_col_ph;
   logic [PH_W-1:0]  cur_row_ph;
   logic             accept;
   logic             col_wrap;
   logic             legal;
   logic             last_px;

   logic [DATA_WIDTH-1:0] line_mem_q [NMEM][IMG_WIDTH];
   logic [DATA_WIDTH-1:0] line_rd    [NMEM];

   logic [DATA_WIDTH-1:0] win_q [KSIZE][KSIZE];
   logic [DATA_WIDTH-1:0] win_d [KSIZE][KSIZE];

   logic             window_valid_q, window_valid_d;
   logic             frame_done_q, frame_done_d;
   logic [ROW_W-1:0] out_row_q, out_row_d;
   logic [COL_W-1:0] out_col_q, out_col_d;

   // Phase stays 0 until the first legal position, then cycles 0..STRIDE-1.
   function automatic logic [PH_W-1:0] ph_next(input logic before_first,
                                                input logic [PH_W-1:0] ph);
      if (before_first || (ph == PH_LAST)) return '0;
      return ph + PH_W'(1);
   endfunction

   assign accept = din_valid;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cur_col    = sof ? '0 : col_q;
      cur_row    = sof ? '0 : row_q;
      cur_col_ph = sof ? '0 : col_ph_q;
      cur_row_ph = sof ? '0 : row_ph_q;

      col_wrap = (cur_col == COL_LAST);
      last_px  = col_wrap && (cur_row == ROW_LAST);
      legal    = (cur_row >= ROW_FIRST_WIN) && (cur_col >= COL_FIRST_WIN) &&
                 (cur_row_ph == '0) && (cur_col_ph == '0);

      col_d    = col_q;
      row_d    = row_q;
      col_ph_d = col_ph_q;
      row_ph_d = row_ph_q;

      if (accept) begin
         row_d    = cur_row;
         row_ph_d = cur_row_ph;
         if (col_wrap) begin
            col_d    = '0;
            col_ph_d = '0;
            if (cur_row == ROW_LAST) begin
               row_d    = '0;
               row_ph_d = '0;
            end else begin
               row_d    = cur_row + ROW_W'(1);
               row_ph_d = ph_next(cur_row < ROW_FIRST_WIN, cur_row_ph);
            end
         end else begin
            col_d    = cur_col + COL_W'(1);
            col_ph_d = ph_next(cur_col < COL_FIRST_WIN, cur_col_ph);
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NMEM; k++) begin
         line_rd[k] = line_mem_q[k][cur_col];
      end
   end

   // NOTE: row memories carry no reset; their contents are never emitted before being rewritten.
   always_ff @(posedge clk) begin
      if (accept) begin
         line_mem_q[0][cur_col] <= din;
         for (int k = 1; k < NMEM; k++) begin
            line_mem_q[k][cur_col] <= line_rd[k-1];
         end
      end
   end

   // Shift each window row left; the new right column is {oldest row .. din}.
   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
         end
         for (int r = 0; r < KSIZE - 1; r++) begin
            win_d[r][KSIZE-1] = line_rd[NMEM-1-r];
         end
         win_d[KSIZE-1][KSIZE-1] = din;
      end
   end

   always_comb begin
      window_valid_d = accept && legal;
      frame_done_d   = accept && last_px;
      out_row_d      = out_row_q;
      out_col_d      = out_col_q;
      if (accept && legal) begin
         out_row_d = cur_row;
         out_col_d = cur_col;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q          <= '0;
         row_q          <= '0;
         col_ph_q       <= '0;
         row_ph_q       <= '0;
         window_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
         out_row_q      <= '0;
         out_col_q      <= '0;
         for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         col_q          <= col_d;
         row_q          <= row_d;
         col_ph_q       <= col_ph_d;
         row_ph_q       <= row_ph_d;
         window_valid_q <= window_valid_d;
         frame_done_q   <= frame_done_d;
         out_row_q      <= out_row_d;
         out_col_q      <= out_col_d;
         win_q          <= win_d;
      end
   end

   always_comb begin
      window_flat = '0;
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE; c++) begin
            window_flat[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
         end
      end
   end

   assign window_valid = window_valid_q;
   assign frame_done   = frame_done_q;
   assign out_row      = out_row_q;
   assign out_col      = out_col_q;

endmodule

// File: tb/tb_window_gen.sv
// Randomized bench for window_gen: two instances (4x4 stride 1, 5x5 stride 2) share one
// input stream and are compared every cycle against a frame-buffer reference model.
module tb_window_gen;

   localparam int DW = 16;
   localparam int K  = 3;
   localparam int FW = K*K*DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          sof;
   logic          din_valid;
   logic [DW-1:0] din;

   logic [FW-1:0] a_flat, b_flat;
   logic          a_valid, b_valid;
   logic [1:0]    a_row, a_col;
   logic [2:0]    b_row, b_col;
   logic          a_done, b_done;

   window_gen #(.DATA_WIDTH(DW), .KSIZE(K), .IMG_WIDTH(4), .IMG_HEIGHT(4), .STRIDE(1)) dut_a (
      .clk(clk), .reset(reset), .sof(sof), .din_valid(din_valid), .din(din),
      .window_flat(a_flat), .window_valid(a_valid), .out_row(a_row), .out_col(a_col),
      .frame_done(a_done));

   window_gen #(.DATA_WIDTH(DW), .KSIZE(K), .IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(2)) dut_b (
      .clk(clk), .reset(reset), .sof(sof), .din_valid(din_valid), .din(din),
      .window_flat(b_flat), .window_valid(b_valid), .out_row(b_row), .out_col(b_col),
      .frame_done(b_done));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: next raster position and the current frame image.
   int            pos_r [2];
   int            pos_c [2];
   logic [DW-1:0] img [2][5][5];
   int            exp_wins [2];
   int            obs_wins [2];
   int            obs_dones [2];
   logic [FW-1:0] first_win [2];
   logic [FW-1:0] last_win [2];

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] pack_win(input int r0, input int r1, input int r2);
      logic [FW-1:0] w;
      int base [3];
      base = '{r0, r1, r2};
      w = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            w[(r*K+c)*DW +: DW] = DW'(base[r] + c);
      return w;
   endfunction

   task automatic clear_counts();
      for (int d = 0; d < 2; d++) begin
         exp_wins[d]  = 0;
         obs_wins[d]  = 0;
         obs_dones[d] = 0;
         first_win[d] = '0;
         last_win[d]  = '0;
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         pos_r[d] = 0;
         pos_c[d] = 0;
      end
   endtask

   task automatic model_check(input int d, input logic s, input logic v, input logic [DW-1:0] px);
      int w, h, st, r, c;
      logic exp_v, exp_done, obs_v, obs_done;
      logic [FW-1:0] exp_win, obs_win, obs_row, obs_col;
      string p;
      p  = (d == 0) ? "a" : "b";
      w  = (d == 0) ? 4 : 5;
      h  = w;
      st = (d == 0) ? 1 : 2;
      obs_v    = (d == 0) ? a_valid : b_valid;
      obs_done = (d == 0) ? a_done : b_done;
      obs_win  = (d == 0) ? a_flat : b_flat;
      obs_row  = (d == 0) ? FW'(a_row) : FW'(b_row);
      obs_col  = (d == 0) ? FW'(a_col) : FW'(b_col);
      exp_v = 1'b0;
      exp_done = 1'b0;
      exp_win = '0;
      r = 0;
      c = 0;
      if (v) begin
         r = s ? 0 : pos_r[d];
         c = s ? 0 : pos_c[d];
         img[d][r][c] = px;
         exp_v = (r >= K-1) && (c >= K-1) && ((r-K+1) % st == 0) && ((c-K+1) % st == 0);
         exp_done = (r == h-1) && (c == w-1);
         if (exp_v)
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  exp_win[(i*K+j)*DW +: DW] = img[d][r-K+1+i][c-K+1+j];
         pos_c[d] = c + 1;
         pos_r[d] = r;
         if (pos_c[d] == w) begin
            pos_c[d] = 0;
            pos_r[d] = (r + 1 == h) ? 0 : r + 1;
         end
      end
      check({p, "_window_valid"}, FW'(obs_v), FW'(exp_v));
      check({p, "_frame_done"}, FW'(obs_done), FW'(exp_done));
      if (exp_v) begin
         exp_wins[d]++;
         check({p, "_window_flat"}, obs_win, exp_win);
         check({p, "_out_row"}, obs_row, FW'(r));
         check({p, "_out_col"}, obs_col, FW'(c));
      end
      if (obs_v) begin
         if (obs_wins[d] == 0) first_win[d] = obs_win;
         last_win[d] = obs_win;
         obs_wins[d]++;
      end
      if (obs_done) obs_dones[d]++;
   endtask

   task automatic step(input logic s, input logic v, input logic [DW-1:0] px);
      sof = s;
      din_valid = v;
      din = px;
      @(posedge clk);
      #1;
      model_check(0, s, v, px);
      model_check(1, s, v, px);
   endtask

   task automatic idle();
      step(1'($urandom_range(0, 1)), 1'b0, DW'($urandom));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a_flat"}, a_flat, '0);
      check({tag, "_a_ctl"}, FW'({a_valid, a_done, a_row, a_col}), '0);
      check({tag, "_b_flat"}, b_flat, '0);
      check({tag, "_b_ctl"}, FW'({b_valid, b_done, b_row, b_col}), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sof = 1'b0;
      din_valid = 1'b0;
      din = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      model_reset();
      clear_counts();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      #2 reset = 1'b1;

      // Back-to-back 4x4 frame.
      clear_counts();
      for (int i = 1; i <= 16; i++) step(i == 1, 1'b1, DW'(i));
      check("s1_a_windows", FW'(obs_wins[0]), FW'(4));
      check("s1_a_done", FW'(obs_dones[0]), FW'(1));
      check("s1_a_first", first_win[0], pack_win(1, 5, 9));
      check("s1_a_last", last_win[0], pack_win(6, 10, 14));

      // Same frame with random stalls.
      clear_counts();
      for (int i = 1; i <= 16; i++) begin
         while ($urandom_range(0, 1) == 0) idle();
         step(i == 1, 1'b1, DW'(i));
      end
      check("s2_a_windows", FW'(obs_wins[0]), FW'(4));
      check("s2_a_first", first_win[0], pack_win(1, 5, 9));
      check("s2_a_last", last_win[0], pack_win(6, 10, 14));

      // 5x5 frame with stride 2.
      clear_counts();
      for (int i = 1; i <= 25; i++) step(i == 1, 1'b1, DW'(i));
      check("s3_b_windows", FW'(obs_wins[1]), FW'(4));
      check("s3_b_last", last_win[1], pack_win(13, 18, 23));
      check("s3_b_done", FW'(obs_dones[1]), FW'(1));

      // Two frames back-to-back; only the second frame is counted.
      for (int i = 1; i <= 16; i++) step(i == 1, 1'b1, DW'(i));
      clear_counts();
      for (int i = 101; i <= 116; i++) step(1'b0, 1'b1, DW'(i));
      check("s4_a_windows", FW'(obs_wins[0]), FW'(4));
      check("s4_a_first", first_win[0], pack_win(101, 105, 109));

      // Frame aborted by sof on its 7th pixel.
      clear_counts();
      for (int i = 1; i <= 6; i++) step(i == 1, 1'b1, DW'(i));
      for (int i = 201; i <= 216; i++) step(i == 201, 1'b1, DW'(i));
      check("s5_a_windows", FW'(obs_wins[0]), FW'(4));
      check("s5_a_done", FW'(obs_dones[0]), FW'(1));
      check("s5_a_first", first_win[0], pack_win(201, 205, 209));

      // Asynchronous reset between edges right after a window.
      for (int i = 1; i <= 11; i++) step(i == 1, 1'b1, DW'(i));
      check("s6_pre_valid", FW'(a_valid), FW'(1));
      #2 reset = 1'b0;
      #1;
      check_all_zero("s6_async_reset");
      model_reset();
      #2 reset = 1'b1;
      clear_counts();
      for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, DW'(i));
      check("s6_a_windows", FW'(obs_wins[0]), FW'(4));
      check("s6_a_first", first_win[0], pack_win(1, 5, 9));

      // Random signed pixels with random stalls over several frames.
      clear_counts();
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 2) == 0) idle();
         step(i == 0, 1'b1, DW'($urandom));
      end
      check("s7_a_windows", FW'(obs_wins[0]), FW'(exp_wins[0]));
      check("s7_b_windows", FW'(obs_wins[1]), FW'(exp_wins[1]));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
